// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS pipe: load-use stalls,
// branch/jal flushes, registered forwarding selects, memory freeze, stall counter.
module hazard_ctrl #(
  parameter int unsigned STALL_CNT_W = 16,
  parameter int unsigned LINK_REG    = 31
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [2:0]             op_id,
  input  logic [4:0]             rs_id,
  input  logic [4:0]             rt_id,
  input  logic [4:0]             rd_id,
  input  logic                   valid_id,
  input  logic                   br_taken_ex,
  input  logic                   mem_busy,
  output logic                   stall_if,
  output logic                   stall_id,
  output logic                   bubble_ex,
  output logic                   flush_id,
  output logic                   freeze,
  output logic [1:0]             fwd_a,
  output logic [1:0]             fwd_b,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef enum logic [2:0] {
    OP_ADDU = 3'd0,
    OP_SUBU = 3'd1,
    OP_ORI  = 3'd2,
    OP_LW   = 3'd3,
    OP_SW   = 3'd4,
    OP_BEQ  = 3'd5,
    OP_JAL  = 3'd6,
    OP_UND  = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    SEL_RF  = 2'b00,
    SEL_EXM = 2'b01,
    SEL_MWB = 2'b10
  } fwd_t;

  op_t        op_e;
  logic [4:0] dst_id;
  logic       use_rs;
  logic       use_rt;
  logic       is_lw;
  logic       is_jal;

  logic [4:0] ex_dst;
  logic       ex_load;
  logic [4:0] mem_dst;

  logic       load_use;
  fwd_t       sel_a;
  fwd_t       sel_b;

  assign op_e = op_t'(op_id);

  // ID decode: destination and which sources are actually read
  always_comb begin
    dst_id = '0;
    use_rs = 1'b0;
    use_rt = 1'b0;
    is_lw  = 1'b0;
    is_jal = 1'b0;
    if (valid_id) begin
      unique case (op_e)
        OP_ADDU, OP_SUBU: begin
          dst_id = rd_id;
          use_rs = 1'b1;
          use_rt = 1'b1;
        end
        OP_ORI: begin
          dst_id = rt_id;
          use_rs = 1'b1;
        end
        OP_LW: begin
          dst_id = rt_id;
          use_rs = 1'b1;
          is_lw  = 1'b1;
        end
        OP_SW, OP_BEQ: begin
          use_rs = 1'b1;
          use_rt = 1'b1;
        end
        OP_JAL: begin
          dst_id = LINK_REG[4:0];
          is_jal = 1'b1;
        end
        OP_UND: ;
        default: ;
      endcase
    end
  end

  function automatic fwd_t fwd_sel(input logic [4:0] src, input logic used,
                                   input logic [4:0] exd, input logic [4:0] memd);
    fwd_t sel;
    sel = SEL_RF;
    if (used && src != '0) begin
      if (src == exd)
        sel = SEL_EXM;
      else if (src == memd)
        sel = SEL_MWB;
    end
    return sel;
  endfunction

  always_comb begin
    load_use = ex_load && (ex_dst != '0) &&
               ((use_rs && rs_id == ex_dst) || (use_rt && rt_id == ex_dst));
    sel_a    = fwd_sel(rs_id, use_rs, ex_dst, mem_dst);
    sel_b    = fwd_sel(rt_id, use_rt, ex_dst, mem_dst);
  end

  // Control outputs are forced low while reset is asserted so the async reset
  // clears them immediately even with hazard-causing inputs present.
  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    bubble_ex = 1'b0;
    flush_id  = 1'b0;
    freeze    = 1'b0;
    if (rst_n) begin
      if (mem_busy) begin
        freeze = 1'b1;
      end else if (br_taken_ex) begin
        flush_id  = 1'b1;
        bubble_ex = 1'b1;
      end else if (load_use) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        bubble_ex = 1'b1;
      end else if (is_jal) begin
        flush_id = 1'b1;
      end
    end
  end

  // bubble_ex covers both the branch kill and the load-use stall; jal advances
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_dst  <= '0;
      ex_load <= 1'b0;
      mem_dst <= '0;
      fwd_a   <= '0;
      fwd_b   <= '0;
    end else if (!mem_busy) begin
      mem_dst <= ex_dst;
      if (bubble_ex) begin
        ex_dst  <= '0;
        ex_load <= 1'b0;
        fwd_a   <= '0;
        fwd_b   <= '0;
      end else begin
        ex_dst  <= dst_id;
        ex_load <= is_lw;
        fwd_a   <= sel_a;
        fwd_b   <= sel_b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if ((stall_if || freeze) && stall_cnt != '1)
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed, table-driven bench for hazard_ctrl plus hand-written freeze,
// saturation and asynchronous-reset sequences.
module tb_hazard_ctrl;

  localparam int unsigned CW = 4;

  logic          clk;
  logic          rst_n;
  logic [2:0]    op_id;
  logic [4:0]    rs_id, rt_id, rd_id;
  logic          valid_id, br_taken_ex, mem_busy;
  logic          stall_if, stall_id, bubble_ex, flush_id, freeze;
  logic [1:0]    fwd_a, fwd_b;
  logic [CW-1:0] stall_cnt;

  int compared   = 0;
  int mismatched = 0;

  hazard_ctrl #(.STALL_CNT_W(CW), .LINK_REG(31)) dut (
    .clk(clk), .rst_n(rst_n), .op_id(op_id), .rs_id(rs_id), .rt_id(rt_id),
    .rd_id(rd_id), .valid_id(valid_id), .br_taken_ex(br_taken_ex),
    .mem_busy(mem_busy), .stall_if(stall_if), .stall_id(stall_id),
    .bubble_ex(bubble_ex), .flush_id(flush_id), .freeze(freeze),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [4:0] rs, rt, rd;
    logic       v, br, busy;
    logic       e_stall, e_bub, e_flush, e_frz;
    logic [1:0] e_fa, e_fb;
  } vec_t;

  localparam int NV = 33;
  vec_t vt[NV];

  function automatic vec_t mk(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic v, input logic br,
                              input logic busy, input logic es, input logic eb,
                              input logic ef, input logic ez, input logic [1:0] fa,
                              input logic [1:0] fb);
    vec_t r;
    r.op = op; r.rs = rs; r.rt = rt; r.rd = rd; r.v = v; r.br = br; r.busy = busy;
    r.e_stall = es; r.e_bub = eb; r.e_flush = ef; r.e_frz = ez; r.e_fa = fa; r.e_fb = fb;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic v, input logic br, input logic busy);
    op_id = op; rs_id = rs; rt_id = rt; rd_id = rd;
    valid_id = v; br_taken_ex = br; mem_busy = busy;
  endtask

  task automatic nop_in();
    drive(3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nop_in();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic chk_ctrl(input string tag, input logic es, input logic eb,
                          input logic ef, input logic ez);
    chk({tag, ".stall_if"},  int'(stall_if),  int'(es));
    chk({tag, ".stall_id"},  int'(stall_id),  int'(es));
    chk({tag, ".bubble_ex"}, int'(bubble_ex), int'(eb));
    chk({tag, ".flush_id"},  int'(flush_id),  int'(ef));
    chk({tag, ".freeze"},    int'(freeze),    int'(ez));
  endtask

  initial begin
    // op: 0 addu 1 subu 2 ori 3 lw 4 sw 5 beq 6 jal 7 und
    // fwd columns show selects registered from the previous row's ID instruction
    vt[0]  = mk(3, 1, 5, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0); // lw r5
    vt[1]  = mk(0, 5, 1, 6, 1, 0, 0,  1, 1, 0, 0, 0, 0); // addu r6,r5,r1: load-use
    vt[2]  = mk(0, 5, 1, 6, 1, 0, 0,  0, 0, 0, 0, 0, 0); // addu advances
    vt[3]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2, 0); // addu EX: fwd_a=10
    vt[4]  = mk(0, 1, 2, 3, 1, 0, 0,  0, 0, 0, 0, 0, 0); // addu r3
    vt[5]  = mk(1, 1, 2, 3, 1, 0, 0,  0, 0, 0, 0, 0, 0); // subu r3
    vt[6]  = mk(2, 3, 7, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0); // ori r7,r3
    vt[7]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0); // ori EX: EX wins
    vt[8]  = mk(0, 1, 2, 4, 1, 0, 0,  0, 0, 0, 0, 0, 0); // addu r4
    vt[9]  = mk(4, 1, 2, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0); // sw (no dst)
    vt[10] = mk(1, 9, 4, 10, 1, 0, 0, 0, 0, 0, 0, 0, 0); // subu r10,r9,r4
    vt[11] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 2); // older producer: 10
    vt[12] = mk(0, 1, 2, 11, 1, 0, 0, 0, 0, 0, 0, 0, 0); // addu r11
    vt[13] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    vt[14] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    vt[15] = mk(0, 11, 11, 12, 1, 0, 0, 0, 0, 0, 0, 0, 0); // three apart
    vt[16] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0); // selects 00
    vt[17] = mk(0, 1, 2, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0); // addu r0
    vt[18] = mk(0, 0, 0, 13, 1, 0, 0, 0, 0, 0, 0, 0, 0); // reads r0
    vt[19] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0); // r0 never forwards
    vt[20] = mk(4, 1, 14, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0); // sw rt=r14
    vt[21] = mk(0, 14, 14, 15, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[22] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0); // no fwd from sw
    vt[23] = mk(3, 1, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0); // lw r0
    vt[24] = mk(0, 0, 0, 16, 1, 0, 0, 0, 0, 0, 0, 0, 0); // no stall on r0
    vt[25] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    vt[26] = mk(3, 1, 17, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0); // lw r17
    vt[27] = mk(0, 17, 1, 18, 1, 1, 0, 0, 1, 1, 0, 0, 0); // branch beats load-use
    vt[28] = mk(0, 17, 2, 18, 1, 0, 0, 0, 0, 0, 0, 0, 0); // ex_dst was cleared
    vt[29] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2, 0); // lw now in WB side: 10
    vt[30] = mk(6, 0, 0, 0, 1, 0, 0,  0, 0, 1, 0, 0, 0); // jal flushes
    vt[31] = mk(0, 31, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0); // reads r31
    vt[32] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0); // jal forwarded from EX

    rst_n = 1'b0;
    nop_in();
    #2;
    chk("reset.stall_cnt", int'(stall_cnt), 0);
    chk("reset.fwd_a", int'(fwd_a), 0);
    do_reset();
    @(negedge clk);
    chk_ctrl("reset", 0, 0, 0, 0);
    chk("reset.fwd_b", int'(fwd_b), 0);
    next_cycle();

    for (int i = 0; i < NV; i++) begin
      drive(vt[i].op, vt[i].rs, vt[i].rt, vt[i].rd, vt[i].v, vt[i].br, vt[i].busy);
      @(negedge clk);
      chk_ctrl($sformatf("vec%0d", i), vt[i].e_stall, vt[i].e_bub, vt[i].e_flush, vt[i].e_frz);
      chk($sformatf("vec%0d.fwd_a", i), int'(fwd_a), int'(vt[i].e_fa));
      chk($sformatf("vec%0d.fwd_b", i), int'(fwd_b), int'(vt[i].e_fb));
      next_cycle();
    end
    chk("table.stall_cnt", int'(stall_cnt), 1);

    // Freeze with a taken branch and a load-use both pending in EX
    do_reset();
    drive(3, 1, 5, 0, 1, 0, 0);
    next_cycle();
    drive(0, 5, 1, 6, 1, 1, 1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_ctrl($sformatf("busy%0d", c), 0, 0, 0, 1);
      next_cycle();
    end
    chk("busy.stall_cnt", int'(stall_cnt), 3);
    mem_busy = 1'b0;
    @(negedge clk);
    chk_ctrl("after_busy", 0, 1, 1, 0);
    next_cycle();
    chk("after_busy.stall_cnt", int'(stall_cnt), 3);

    // Saturation of the 4-bit counter
    do_reset();
    mem_busy = 1'b1;
    repeat (15) next_cycle();
    chk("sat15.stall_cnt", int'(stall_cnt), 15);
    repeat (5) next_cycle();
    chk("sat20.stall_cnt", int'(stall_cnt), 15);

    // Asynchronous reset in the middle of a load-use stall
    drive(3, 1, 5, 0, 1, 0, 0);
    next_cycle();
    drive(0, 5, 1, 6, 1, 0, 0);
    @(negedge clk);
    chk("pre_rst.stall_if", int'(stall_if), 1);
    #1 rst_n = 1'b0;
    #1;
    chk_ctrl("async_rst", 0, 0, 0, 0);
    chk("async_rst.stall_cnt", int'(stall_cnt), 0);
    chk("async_rst.fwd_a", int'(fwd_a), 0);
    nop_in();
    next_cycle();
    #1 rst_n = 1'b1;
    drive(0, 5, 1, 6, 1, 0, 0);
    @(negedge clk);
    chk("post_rst.stall_if", int'(stall_if), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
